// File: rtl/commit_arbiter.sv
// Core-wide configuration constants and the commit arbiter.
// The arbiter collects finished ALU results, grants one source per cycle in
// round-robin order, stages the grant for one cycle, then writes the register
// file (or raises an exception) and returns a one-hot clear to the source.

package core_config_pkg;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
endpackage

module commit_arbiter #(
    parameter int unsigned N_ALU      = 4,
    parameter int unsigned XLEN       = core_config_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_ALU-1:0]              alu_req,
    input  logic [N_ALU-1:0]              alu_valid,
    input  logic [N_ALU*XLEN-1:0]         alu_res,
    input  logic [N_ALU*REG_ADDR_W-1:0]   alu_rd,
    input  logic [N_ALU-1:0]              alu_error,
    output logic [N_ALU-1:0]              alu_clear,
    input  logic                          flush,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          exc_valid,
    output logic [$clog2(N_ALU)-1:0]      exc_src,
    output logic [REG_ADDR_W-1:0]         exc_rd,
    output logic [31:0]                   commit_count
);

    localparam int unsigned IDX_W = $clog2(N_ALU);
    localparam int unsigned CNT_W = 32;

    // Stage register: the single commit in flight between grant and write-back.
    logic                   stage_v_q;
    logic [IDX_W-1:0]       stage_src_q;
    logic [XLEN-1:0]        stage_res_q;
    logic [REG_ADDR_W-1:0]  stage_rd_q;
    logic                   stage_err_q;

    // Round-robin pointer and retired-commit counter.
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;

    // Arbitration signals.
    logic [N_ALU-1:0]       staged_mask;
    logic [N_ALU-1:0]       eligible;
    logic                   grant_v;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand;
    logic [XLEN-1:0]        grant_res;
    logic [REG_ADDR_W-1:0]  grant_rd;
    logic                   grant_err;
    logic                   commit_fire;

    // One-hot mask of the source sitting in the stage register.
    always_comb begin
        staged_mask = '0;
        if (stage_v_q) begin
            staged_mask[stage_src_q] = 1'b1;
        end
    end

    // A source competes only with a valid result and when it is not already staged.
    always_comb begin
        eligible = alu_req & alu_valid & ~staged_mask;
    end

    // Round-robin search starting at ptr; a flush suppresses any grant this cycle.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_ALU; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_ALU);
            if (!grant_v && eligible[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
        if (flush) begin
            grant_v = 1'b0;
        end
    end

    // Select the winning source's payload out of the packed buses.
    always_comb begin
        grant_res = alu_res[32'(grant_idx)*XLEN +: XLEN];
        grant_rd  = alu_rd[32'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
        grant_err = alu_error[grant_idx];
    end

    // Next pointer skips past the winner; next count advances on a non-flushed retire.
    always_comb begin
        commit_fire = stage_v_q & ~flush;
        ptr_d       = ptr_q;
        if (grant_v) begin
            ptr_d = IDX_W'((32'(grant_idx) + 32'd1) % N_ALU);
        end
        count_d = count_q;
        if (commit_fire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Stage register capture; a pending commit is dropped on reset without a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_v_q   <= 1'b0;
            stage_src_q <= '0;
            stage_res_q <= '0;
            stage_rd_q  <= '0;
            stage_err_q <= 1'b0;
        end else begin
            stage_v_q <= grant_v;
            if (grant_v) begin
                stage_src_q <= grant_idx;
                stage_res_q <= grant_res;
                stage_rd_q  <= grant_rd;
                stage_err_q <= grant_err;
            end
        end
    end

    // Arbitration pointer and commit counter (counter wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Write-back and exception outputs decoded from the stage register.
    always_comb begin
        alu_clear = staged_mask;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        exc_valid = 1'b0;
        exc_src   = '0;
        exc_rd    = '0;
        if (stage_v_q) begin
            rf_we     = !stage_err_q && (stage_rd_q != '0) && !flush;
            rf_waddr  = stage_rd_q;
            rf_wdata  = stage_res_q;
            exc_valid = stage_err_q && !flush;
            exc_src   = stage_src_q;
            exc_rd    = stage_rd_q;
        end
        commit_count = count_q;
    end

endmodule
